// File: rtl/iob_cpu_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : iob_cpu_mem_arbiter                                        |
// | Description : Round-robin arbiter folding the CPU instruction and data   |
// |               buses onto a single native memory port. One transaction    |
// |               in flight; optional watchdog completes hung accesses with  |
// |               rdata=0 and a one-cycle timeout pulse.                     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module iob_cpu_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [ADDR_W+DATA_W+DATA_W/8:0] ibus_req,
    output logic [DATA_W:0]                 ibus_resp,
    input  logic [ADDR_W+DATA_W+DATA_W/8:0] dbus_req,
    output logic [DATA_W:0]                 dbus_resp,
    output logic [ADDR_W+DATA_W+DATA_W/8:0] m_req,
    input  logic [DATA_W:0]                 m_resp,
    output logic                            timeout
);

    // Request payload excludes the valid bit (MSB); response ready is the LSB.
    localparam int          c_PAY_W    = ADDR_W + DATA_W + DATA_W / 8;
    localparam logic [0:0]  c_IDLE     = 1'b0;
    localparam logic [0:0]  c_BUSY     = 1'b1;
    localparam bit          c_WD_EN    = (TIMEOUT > 0);
    localparam logic [15:0] c_CNT_LAST = c_WD_EN ? 16'(TIMEOUT - 1) : 16'd0;

    logic [0:0]         r_state;
    logic               r_grant;     // 0 = ibus, 1 = dbus
    logic               r_last;      // most recently granted bus
    logic [c_PAY_W-1:0] r_req_q;
    logic [15:0]        r_cnt;

    logic               w_i_valid;
    logic               w_d_valid;
    logic               w_pick;
    logic               w_s_ready;
    logic               w_expire;
    logic [DATA_W:0]    w_resp;

    assign w_i_valid = ibus_req[c_PAY_W];
    assign w_d_valid = dbus_req[c_PAY_W];
    assign w_s_ready = m_resp[0];

    // A lone requester wins outright; on contention the bus not served last wins.
    assign w_pick = (w_i_valid && w_d_valid) ? ~r_last : w_d_valid;

    // Watchdog fires only if the slave stays silent in the final allowed cycle,
    // so a real response in that same cycle always takes precedence.
    assign w_expire = (r_state == c_BUSY) && c_WD_EN && !w_s_ready && (r_cnt == c_CNT_LAST);

    // Two-state arbitration FSM: latch the winner's request, then wait for completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_grant <= 1'b0;
            r_last  <= 1'b1;
            r_req_q <= '0;
            r_cnt   <= 16'd0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_i_valid || w_d_valid) begin
                        r_grant <= w_pick;
                        r_last  <= w_pick;
                        r_req_q <= w_pick ? dbus_req[c_PAY_W-1:0] : ibus_req[c_PAY_W-1:0];
                        r_cnt   <= 16'd0;
                        r_state <= c_BUSY;
                    end
                end
                c_BUSY: begin
                    if (w_s_ready || w_expire) begin
                        r_state <= c_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // Response for the granted master: real slave data, or a synthetic zero-data ready on expiry.
    always_comb begin
        w_resp = '0;
        if (w_s_ready) begin
            w_resp = m_resp;
        end else if (w_expire) begin
            w_resp = {{DATA_W{1'b0}}, 1'b1};
        end
    end

    // Output steering: everything is quiet in IDLE, so late slave readies never leak through.
    always_comb begin
        m_req     = '0;
        ibus_resp = '0;
        dbus_resp = '0;
        timeout   = 1'b0;
        if (r_state == c_BUSY) begin
            m_req   = {1'b1, r_req_q};
            timeout = w_expire;
            if (r_grant) begin
                dbus_resp = w_resp;
            end else begin
                ibus_resp = w_resp;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_iob_cpu_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_iob_cpu_mem_arbiter                                     |
// | Description : Directed vector table plus randomized traffic checked      |
// |               against a transaction-level reference model.               |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_iob_cpu_mem_arbiter;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int TO    = 4;
    localparam int REQ_W = 1 + AW + DW + DW / 8;
    localparam int RSP_W = DW + 1;

    logic             clk;
    logic             rst;
    logic [REQ_W-1:0] ibus_req;
    logic [RSP_W-1:0] ibus_resp;
    logic [REQ_W-1:0] dbus_req;
    logic [RSP_W-1:0] dbus_resp;
    logic [REQ_W-1:0] m_req;
    logic [RSP_W-1:0] m_resp;
    logic             timeout;

    iob_cpu_mem_arbiter #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .TIMEOUT(TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ibus_req (ibus_req),
        .ibus_resp(ibus_resp),
        .dbus_req (dbus_req),
        .dbus_resp(dbus_resp),
        .m_req    (m_req),
        .m_resp   (m_resp),
        .timeout  (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string            name;
        logic             rst;
        logic [REQ_W-1:0] ireq;
        logic [REQ_W-1:0] dreq;
        logic [RSP_W-1:0] mresp;
        logic [REQ_W-1:0] exp_mreq;
        logic [RSP_W-1:0] exp_iresp;
        logic [RSP_W-1:0] exp_dresp;
        logic             exp_to;
    } vec_t;

    vec_t vq[$];
    int   vectors    = 0;
    int   miscompares = 0;

    function automatic logic [REQ_W-1:0] rq(input bit v, input logic [31:0] a,
                                            input logic [31:0] w, input logic [3:0] s);
        return {v, a, w, s};
    endfunction

    function automatic logic [RSP_W-1:0] rs(input logic [31:0] d, input bit r);
        return {d, r};
    endfunction

    task automatic add(input string n, input logic r, input logic [REQ_W-1:0] ir,
                       input logic [REQ_W-1:0] dr, input logic [RSP_W-1:0] mr,
                       input logic [REQ_W-1:0] em, input logic [RSP_W-1:0] ei,
                       input logic [RSP_W-1:0] ed, input logic et);
        vec_t v;
        v.name = n; v.rst = r; v.ireq = ir; v.dreq = dr; v.mresp = mr;
        v.exp_mreq = em; v.exp_iresp = ei; v.exp_dresp = ed; v.exp_to = et;
        vq.push_back(v);
    endtask

    task automatic check(input string n, input logic [REQ_W-1:0] em,
                         input logic [RSP_W-1:0] ei, input logic [RSP_W-1:0] ed,
                         input logic et);
        vectors++;
        if ({m_req, ibus_resp, dbus_resp, timeout} !== {em, ei, ed, et}) begin
            miscompares++;
            $display("FAIL %s: got m_req=%h ibus_resp=%h dbus_resp=%h timeout=%b, want m_req=%h ibus_resp=%h dbus_resp=%h timeout=%b",
                     n, m_req, ibus_resp, dbus_resp, timeout, em, ei, ed, et);
        end
    endtask

    // Reference model state (transaction level)
    int               mdl_owner;   // -1 idle, 0 ibus, 1 dbus
    int               mdl_age;     // 1-based count of cycles in service
    int               mdl_last;
    logic [REQ_W-1:0] mdl_lat;

    initial begin
        logic [REQ_W-1:0] i0, d0;
        int               ni, nd;

        rst = 1'b1; ibus_req = '0; dbus_req = '0; m_resp = '0;
        repeat (2) @(posedge clk);

        // 1: single ibus read, slave answers two cycles after the request
        add("t1_reset", 1, '0, '0, '0, '0, '0, '0, 0);
        i0 = rq(1, 32'h100, 32'h0, 4'h0);
        add("t1_idle",  0, i0, '0, '0, '0, '0, '0, 0);
        add("t1_busy1", 0, i0, '0, '0, i0, '0, '0, 0);
        add("t1_ready", 0, i0, '0, rs(32'h13, 1), i0, rs(32'h13, 1), '0, 0);
        add("t1_after", 0, '0, '0, '0, '0, '0, '0, 0);

        // 2: both valid from reset, ibus first, one IDLE gap, then dbus write
        add("t2_reset", 1, '0, '0, '0, '0, '0, '0, 0);
        i0 = rq(1, 32'h0, 32'h0, 4'h0);
        d0 = rq(1, 32'h8, 32'hCAFE, 4'hF);
        add("t2_idle",  0, i0, d0, '0, '0, '0, '0, 0);
        add("t2_ibus",  0, i0, d0, rs(32'hAA, 1), i0, rs(32'hAA, 1), '0, 0);
        add("t2_gap",   0, '0, d0, '0, '0, '0, '0, 0);
        add("t2_dbus",  0, '0, d0, rs(32'h0, 1), d0, '0, rs(32'h0, 1), 0);
        add("t2_after", 0, '0, '0, '0, '0, '0, '0, 0);

        // 3: both continuously valid, grants alternate I,D,I,D,I,D
        add("t3_reset", 1, '0, '0, '0, '0, '0, '0, 0);
        ni = 0; nd = 0;
        for (int k = 0; k < 6; k++) begin
            i0 = rq(1, 32'h1000 + ni, 32'h0, 4'h0);
            d0 = rq(1, 32'h2000 + nd, 32'h10 + nd, 4'h3);
            add("t3_idle", 0, i0, d0, '0, '0, '0, '0, 0);
            if (k % 2 == 0) begin
                add("t3_grant_i", 0, i0, d0, rs(32'h500 + k, 1), i0, rs(32'h500 + k, 1), '0, 0);
                ni++;
            end else begin
                add("t3_grant_d", 0, i0, d0, rs(32'h500 + k, 1), d0, '0, rs(32'h500 + k, 1), 0);
                nd++;
            end
        end
        add("t3_after", 0, '0, '0, '0, '0, '0, '0, 0);

        // 4: slave never answers; watchdog completes in the 4th BUSY cycle
        add("t4_reset", 1, '0, '0, '0, '0, '0, '0, 0);
        i0 = rq(1, 32'h200, 32'h0, 4'h0);
        add("t4_idle",  0, i0, '0, '0, '0, '0, '0, 0);
        add("t4_busy1", 0, i0, '0, '0, i0, '0, '0, 0);
        add("t4_busy2", 0, i0, '0, '0, i0, '0, '0, 0);
        add("t4_busy3", 0, i0, '0, '0, i0, '0, '0, 0);
        add("t4_expire", 0, i0, '0, '0, i0, rs(32'h0, 1), '0, 1);
        add("t4_spurious", 0, '0, '0, rs(32'h77, 1), '0, '0, '0, 0);

        // 5: reset in the 2nd BUSY cycle drops the transaction
        add("t5_reset", 1, '0, '0, '0, '0, '0, '0, 0);
        d0 = rq(1, 32'h300, 32'h1234, 4'h1);
        add("t5_idle",  0, '0, d0, '0, '0, '0, '0, 0);
        add("t5_busy1", 0, '0, d0, '0, d0, '0, '0, 0);
        add("t5_rst_busy2", 1, '0, d0, '0, d0, '0, '0, 0);
        add("t5_post1", 0, '0, '0, rs(32'h99, 1), '0, '0, '0, 0);
        add("t5_post2", 0, '0, '0, rs(32'h99, 1), '0, '0, '0, 0);

        // 6: slave ready in the watchdog's final cycle wins
        i0 = rq(1, 32'h400, 32'h0, 4'h0);
        add("t6_idle",  0, i0, '0, '0, '0, '0, '0, 0);
        add("t6_busy1", 0, i0, '0, '0, i0, '0, '0, 0);
        add("t6_busy2", 0, i0, '0, '0, i0, '0, '0, 0);
        add("t6_busy3", 0, i0, '0, '0, i0, '0, '0, 0);
        add("t6_tie",   0, i0, '0, rs(32'h55, 1), i0, rs(32'h55, 1), '0, 0);
        add("t6_after", 0, '0, '0, '0, '0, '0, '0, 0);

        for (int k = 0; k < vq.size(); k++) begin
            @(negedge clk);
            rst = vq[k].rst; ibus_req = vq[k].ireq; dbus_req = vq[k].dreq; m_resp = vq[k].mresp;
            #1;
            check(vq[k].name, vq[k].exp_mreq, vq[k].exp_iresp, vq[k].exp_dresp, vq[k].exp_to);
        end

        // Randomized traffic against the reference model
        begin
            logic [REQ_W-1:0] ib, db, em;
            logic [RSP_W-1:0] ei, ed, r;
            logic             et, done, iv, dv;

            mdl_owner = -1; mdl_age = 0; mdl_last = 1; mdl_lat = '0;
            ib = '0; db = '0;
            for (int cyc = 0; cyc < 3000; cyc++) begin
                @(negedge clk);
                rst      = (cyc == 0) || ($urandom_range(0, 149) == 0);
                ibus_req = ib;
                dbus_req = db;
                m_resp   = {32'($urandom), ($urandom_range(0, 3) == 0)};
                #1;
                em = '0; ei = '0; ed = '0; et = 1'b0; done = 1'b0; r = '0;
                if (mdl_owner >= 0) begin
                    em = mdl_lat;
                    if (m_resp[0]) begin
                        r = m_resp; done = 1'b1;
                    end else if (TO > 0 && mdl_age == TO) begin
                        r = rs(32'h0, 1); et = 1'b1; done = 1'b1;
                    end
                    if (mdl_owner == 1) ed = r; else ei = r;
                end
                check("random", em, ei, ed, et);

                iv = ib[REQ_W-1];
                dv = db[REQ_W-1];
                if (rst) begin
                    mdl_owner = -1; mdl_last = 1;
                end else if (mdl_owner < 0) begin
                    if (iv || dv) begin
                        mdl_owner = (iv && dv) ? 1 - mdl_last : (iv ? 0 : 1);
                        mdl_last  = mdl_owner;
                        mdl_age   = 1;
                        mdl_lat   = (mdl_owner == 1) ? db : ib;
                    end
                end else if (done) begin
                    mdl_owner = -1;
                end else begin
                    mdl_age++;
                end

                // Masters hold a request until served, then pick a new one or go quiet
                if (rst || !iv || ei[0])
                    ib = rq($urandom_range(0, 2) != 0, $urandom, $urandom, 4'h0);
                if (rst || !dv || ed[0])
                    db = rq($urandom_range(0, 2) != 0, $urandom, $urandom, 4'($urandom));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
